// File: rtl/uart_pkg.sv
// Shared definitions for the UART bus controller: register offsets, CON bit
// positions, TX sequencer state encoding and the CON read-word packer.
package uart_pkg;

    localparam logic [31:0] OFF_TXD = 32'h0000_0000;
    localparam logic [31:0] OFF_RXD = 32'h0000_0004;
    localparam logic [31:0] OFF_CON = 32'h0000_0008;

    localparam int CON_RX_IE   = 0;
    localparam int CON_TX_IE   = 1;
    localparam int CON_RX_DONE = 2;
    localparam int CON_TX_DONE = 3;
    localparam int CON_TX_BUSY = 4;
    localparam int CON_RX_OVF  = 5;
    localparam int CON_TX_ERR  = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_BUSY  = 2'b10
    } tx_state_e;

    function automatic logic [31:0] con_word(
        input logic rx_ie,
        input logic tx_ie,
        input logic rx_done,
        input logic tx_done,
        input logic tx_busy,
        input logic rx_ovf,
        input logic tx_err
    );
        return {25'h000_0000, tx_err, rx_ovf, tx_busy, tx_done, rx_done, tx_ie, rx_ie};
    endfunction

endpackage

// File: rtl/uart_status_sync.sv
// Multi-flop synchronizer for a baud-domain status line; idles high and
// provides one-cycle rise/fall pulses taken after the last synchronizer stage.
module uart_status_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Shift chain plus one extra flop for edge detection
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b1}};
            prev_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign sync_out = sync_r[SYNC_STAGES-1];
    assign rise     = sync_out & ~prev_r;
    assign fall     = ~sync_out & prev_r;

endmodule

// File: rtl/uart_bus_ctrl.sv
// Memory-mapped UART controller: TXD/RXD/CON register decode, one-deep TX
// holding register, start/busy handshake sequencer and RX capture with overflow.
module uart_bus_ctrl
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h4000_0018,
    parameter int          SYNC_STAGES   = 2,
    parameter int          START_TIMEOUT = 12000
) (
    input  logic        sysclk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_wr,
    input  logic        mem_rd,
    output logic [31:0] rdata,
    input  logic [7:0]  rx_data,
    input  logic        rx_status,
    input  logic        tx_status,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    output logic        irq
);

    localparam logic [31:0] TXD_ADDR = BASE_ADDR + OFF_TXD;
    localparam logic [31:0] RXD_ADDR = BASE_ADDR + OFF_RXD;
    localparam logic [31:0] CON_ADDR = BASE_ADDR + OFF_CON;
    localparam int          CNT_W    = $clog2(START_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

    tx_state_e        state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [7:0]       tx_data_r, tx_data_s, hold_r, hold_s, rx_buf_r, rx_buf_s;
    logic             tx_en_r, tx_en_s, hold_valid_r, hold_valid_s, irq_r, irq_s;
    logic             rx_ie_r, rx_ie_s, tx_ie_r, tx_ie_s, rx_done_r, rx_done_s;
    logic             tx_done_r, tx_done_s, rx_ovf_r, rx_ovf_s, tx_err_r, tx_err_s;
    logic             tx_done_set_s, tx_err_set_s, tx_busy_s;
    logic             wr_txd_s, wr_con_s, rd_rxd_s;
    logic             rx_sync_s, rx_rise_s, rx_fall_s, tx_sync_s, tx_rise_s, tx_fall_s;
    logic             unused_s;

    uart_status_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rx_sync (
        .sysclk(sysclk), .rst_n(rst_n), .async_in(rx_status),
        .sync_out(rx_sync_s), .rise(rx_rise_s), .fall(rx_fall_s)
    );

    uart_status_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tx_sync (
        .sysclk(sysclk), .rst_n(rst_n), .async_in(tx_status),
        .sync_out(tx_sync_s), .rise(tx_rise_s), .fall(tx_fall_s)
    );

    assign unused_s = ^{wdata[31:8], wdata[4], wdata[2], rx_sync_s, rx_fall_s, tx_fall_s};

    // A simultaneous write suppresses the read side-effect
    assign wr_txd_s  = mem_wr & (addr == TXD_ADDR);
    assign wr_con_s  = mem_wr & (addr == CON_ADDR);
    assign rd_rxd_s  = mem_rd & ~mem_wr & (addr == RXD_ADDR);
    assign tx_busy_s = (state_r != ST_IDLE) | hold_valid_r;

    // Read mux, combinational from the address
    always_comb begin
        if (addr == TXD_ADDR) begin
            rdata = {24'h00_0000, tx_data_r};
        end else if (addr == RXD_ADDR) begin
            rdata = {24'h00_0000, rx_buf_r};
        end else if (addr == CON_ADDR) begin
            rdata = con_word(rx_ie_r, tx_ie_r, rx_done_r, tx_done_r, tx_busy_s, rx_ovf_r, tx_err_r);
        end else begin
            rdata = 32'h0000_0000;
        end
    end

    // TX sequencer, holding register and CON/RX next-state logic
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        tx_en_s       = tx_en_r;
        tx_data_s     = tx_data_r;
        hold_s        = hold_r;
        hold_valid_s  = hold_valid_r;
        tx_done_set_s = 1'b0;
        tx_err_set_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (hold_valid_r) begin
                    tx_data_s    = hold_r;
                    hold_valid_s = 1'b0;
                    tx_en_s      = 1'b1;
                    cnt_s        = {CNT_W{1'b0}};
                    state_s      = ST_START;
                end else if (wr_txd_s) begin
                    tx_data_s = wdata[7:0];
                    tx_en_s   = 1'b1;
                    cnt_s     = {CNT_W{1'b0}};
                    state_s   = ST_START;
                end else begin
                    tx_en_s = 1'b0;
                end
            end
            ST_START: begin
                if (!tx_sync_s) begin
                    tx_en_s = 1'b0;
                    state_s = ST_BUSY;
                end else if (cnt_r == CNT_LAST) begin
                    tx_en_s      = 1'b0;
                    tx_err_set_s = 1'b1;
                    state_s      = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_BUSY: begin
                if (tx_rise_s) begin
                    tx_done_set_s = 1'b1;
                    state_s       = ST_IDLE;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            default: begin
                tx_en_s = 1'b0;
                state_s = ST_IDLE;
            end
        endcase

        // Writes that cannot go straight to the sender use the holding register
        if (wr_txd_s && (state_r != ST_IDLE || hold_valid_r)) begin
            if (!hold_valid_s) begin
                hold_s       = wdata[7:0];
                hold_valid_s = 1'b1;
            end else begin
                tx_err_set_s = 1'b1;
            end
        end else begin
            hold_s = hold_s;
        end

        rx_ie_s   = wr_con_s ? wdata[CON_RX_IE] : rx_ie_r;
        tx_ie_s   = wr_con_s ? wdata[CON_TX_IE] : tx_ie_r;
        tx_done_s = tx_done_set_s | (tx_done_r & ~(wr_con_s & wdata[CON_TX_DONE]));
        tx_err_s  = tx_err_set_s | (tx_err_r & ~(wr_con_s & wdata[CON_TX_ERR]));
        rx_done_s = rx_rise_s | (rx_done_r & ~rd_rxd_s);
        rx_ovf_s  = (rx_rise_s & rx_done_r & ~rd_rxd_s) |
                    (rx_ovf_r & ~(wr_con_s & wdata[CON_RX_OVF]));
        rx_buf_s  = rx_rise_s ? rx_data : rx_buf_r;
        irq_s     = (tx_done_s & tx_ie_s) | (rx_done_s & rx_ie_s);
    end

    // State and register update
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            tx_en_r      <= 1'b0;
            tx_data_r    <= 8'h00;
            hold_r       <= 8'h00;
            hold_valid_r <= 1'b0;
            rx_buf_r     <= 8'h00;
            rx_ie_r      <= 1'b0;
            tx_ie_r      <= 1'b0;
            rx_done_r    <= 1'b0;
            tx_done_r    <= 1'b0;
            rx_ovf_r     <= 1'b0;
            tx_err_r     <= 1'b0;
            irq_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            tx_en_r      <= tx_en_s;
            tx_data_r    <= tx_data_s;
            hold_r       <= hold_s;
            hold_valid_r <= hold_valid_s;
            rx_buf_r     <= rx_buf_s;
            rx_ie_r      <= rx_ie_s;
            tx_ie_r      <= tx_ie_s;
            rx_done_r    <= rx_done_s;
            tx_done_r    <= tx_done_s;
            rx_ovf_r     <= rx_ovf_s;
            tx_err_r     <= tx_err_s;
            irq_r        <= irq_s;
        end
    end

    assign tx_en   = tx_en_r;
    assign tx_data = tx_data_r;
    assign irq     = irq_r;

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Directed bench for uart_bus_ctrl: the sender and receiver are driven by hand
// and every register/output is compared with hand-computed values.
module tb_uart_bus_ctrl;

    localparam logic [31:0] BASE = 32'h4000_0018;
    localparam logic [31:0] TXD  = 32'h4000_0018;
    localparam logic [31:0] RXD  = 32'h4000_001C;
    localparam logic [31:0] CON  = 32'h4000_0020;

    logic        sysclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = 32'h0000_0000;
    logic [31:0] wdata = 32'h0000_0000;
    logic        mem_wr = 1'b0;
    logic        mem_rd = 1'b0;
    logic [31:0] rdata;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_status = 1'b1;
    logic        tx_status = 1'b1;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        irq;

    int tests = 0;
    int fails = 0;
    int n     = 0;

    uart_bus_ctrl dut (
        .sysclk(sysclk), .rst_n(rst_n), .addr(addr), .wdata(wdata),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .rdata(rdata), .rx_data(rx_data),
        .rx_status(rx_status), .tx_status(tx_status), .tx_data(tx_data),
        .tx_en(tx_en), .irq(irq)
    );

    always #5 sysclk = ~sysclk;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr   = a;
        wdata  = d;
        mem_wr = 1'b1;
        tick();
        mem_wr = 1'b0;
    endtask

    task automatic wait_tx_en(input logic val, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (tx_en === val) break;
            tick();
        end
    endtask

    task automatic wait_con_bit(input int b, input logic val, input int max_cycles);
        addr = CON;
        #1;
        for (int i = 0; i < max_cycles; i++) begin
            if (rdata[b] === val) break;
            tick();
        end
    endtask

    task automatic rx_byte(input logic [7:0] d);
        rx_data   = d;
        rx_status = 1'b0;
        repeat (3) tick();
        rx_status = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_tx_en", {31'h0, tx_en}, 32'h0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk_reg("rst_con", CON, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single byte: start handshake, busy, completion, interrupt, W1C
        bus_write(CON, 32'h0000_0003);
        chk_reg("con_ie", CON, 32'h0000_0003);
        bus_write(TXD, 32'h0000_0055);
        chk("tx55_en", {31'h0, tx_en}, 32'h1);
        chk("tx55_data", {24'h0, tx_data}, 32'h55);
        chk_reg("tx55_con_start", CON, 32'h0000_0013);
        chk_reg("txd_read", TXD, 32'h0000_0055);
        tx_status = 1'b0;
        wait_tx_en(1'b0, 10);
        chk("tx55_en_drop", {31'h0, tx_en}, 32'h0);
        chk_reg("tx55_con_busy", CON, 32'h0000_0013);
        tx_status = 1'b1;
        wait_con_bit(3, 1'b1, 10);
        chk_reg("tx55_con_done", CON, 32'h0000_000B);
        chk("tx55_irq", {31'h0, irq}, 32'h1);
        bus_write(CON, 32'h0000_000B);
        chk_reg("tx55_w1c", CON, 32'h0000_0003);
        chk("tx55_irq_clr", {31'h0, irq}, 32'h0);

        // Back-to-back A1/A2/A3: A2 held, A3 dropped
        bus_write(TXD, 32'h0000_00A1);
        bus_write(TXD, 32'h0000_00A2);
        bus_write(TXD, 32'h0000_00A3);
        chk("a1_data", {24'h0, tx_data}, 32'hA1);
        chk_reg("a3_drop_con", CON, 32'h0000_0053);
        tx_status = 1'b0;
        wait_tx_en(1'b0, 10);
        tx_status = 1'b1;
        repeat (2) tick();
        wait_tx_en(1'b1, 10);
        chk("a2_en", {31'h0, tx_en}, 32'h1);
        chk("a2_data", {24'h0, tx_data}, 32'hA2);
        chk_reg("a2_con", CON, 32'h0000_005B);
        tx_status = 1'b0;
        wait_tx_en(1'b0, 10);
        tx_status = 1'b1;
        wait_con_bit(4, 1'b0, 20);
        chk_reg("a2_idle_con", CON, 32'h0000_004B);
        chk("a2_data_held", {24'h0, tx_data}, 32'hA2);
        bus_write(CON, 32'h0000_004B);
        chk_reg("a_w1c", CON, 32'h0000_0003);

        // RX capture with exact synchronizer latency, then read-to-clear
        rx_data   = 8'h3C;
        rx_status = 1'b0;
        repeat (3) tick();
        rx_status = 1'b1;
        repeat (2) tick();
        chk_reg("rx_lat_early", CON, 32'h0000_0003);
        tick();
        chk_reg("rx_lat_done", CON, 32'h0000_0007);
        tick();
        chk("rx_irq", {31'h0, irq}, 32'h1);
        addr   = RXD;
        mem_rd = 1'b1;
        #1;
        chk("rx_read", rdata, 32'h0000_003C);
        tick();
        mem_rd = 1'b0;
        chk_reg("rx_cleared", CON, 32'h0000_0003);
        chk("rx_irq_clr", {31'h0, irq}, 32'h0);

        // Overflow: newest wins; write+read together keeps rx_done
        rx_byte(8'h11);
        rx_byte(8'h22);
        chk_reg("ovf_con", CON, 32'h0000_0027);
        chk_reg("ovf_rxd", RXD, 32'h0000_0022);
        addr   = RXD;
        wdata  = 32'h0000_0000;
        mem_wr = 1'b1;
        mem_rd = 1'b1;
        tick();
        mem_wr = 1'b0;
        mem_rd = 1'b0;
        chk_reg("wr_rd_keep", CON, 32'h0000_0027);
        bus_write(CON, 32'h0000_0023);
        chk_reg("ovf_w1c", CON, 32'h0000_0007);

        // Misaligned and unmapped accesses are ignored
        bus_write(BASE + 32'h1, 32'h0000_00EE);
        chk("misalign_en", {31'h0, tx_en}, 32'h0);
        bus_write(CON + 32'h1, 32'h0000_0000);
        chk_reg("misalign_con", CON, 32'h0000_0007);
        chk_reg("unmapped_rd", BASE + 32'hC, 32'h0);
        addr   = RXD;
        mem_rd = 1'b1;
        tick();
        mem_rd = 1'b0;

        // Start timeout: sender never acknowledges
        bus_write(TXD, 32'h0000_0077);
        n = 0;
        for (int i = 0; i < 12100; i++) begin
            if (tx_en === 1'b0) break;
            tick();
            n++;
        end
        chk("to_en", {31'h0, tx_en}, 32'h0);
        chk("to_cycles", {31'h0, (n >= 11998 && n <= 12001)}, 32'h1);
        chk_reg("to_con", CON, 32'h0000_0043);
        bus_write(CON, 32'h0000_0043);
        chk_reg("to_w1c", CON, 32'h0000_0003);

        // Asynchronous reset in BUSY, then recovery
        rx_byte(8'h5A);
        chk("pre_rst_irq", {31'h0, irq}, 32'h1);
        bus_write(TXD, 32'h0000_0099);
        tx_status = 1'b0;
        wait_tx_en(1'b0, 10);
        chk("pre_rst_data", {24'h0, tx_data}, 32'h99);
        rst_n = 1'b0;
        #2;
        chk("arst_data", {24'h0, tx_data}, 32'h0);
        chk("arst_irq", {31'h0, irq}, 32'h0);
        chk("arst_en", {31'h0, tx_en}, 32'h0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        tx_status = 1'b1;
        repeat (6) tick();
        chk_reg("post_rst_con", CON, 32'h0);
        bus_write(TXD, 32'h0000_0042);
        chk("post_rst_en", {31'h0, tx_en}, 32'h1);
        chk("post_rst_data", {24'h0, tx_data}, 32'h42);
        chk_reg("post_rst_busy", CON, 32'h0000_0010);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
